// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, programmable bit period and drain interrupt.
// Latency: a byte pushed at edge N is popped at N+1 and tx_o falls after N+1. Each frame is 10 bit periods.
// Backpressure: none on the bus. A push into a full FIFO is dropped and the sticky overflow flag is set.
module uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        int_o
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push_req, push, pop;

  // Programmable registers
  logic [15:0]   bauddiv, div_eff;
  logic          tx_en, int_en, overflow;

  // Frame engine
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [15:0]   baud_cnt;
  logic          tx_q, busy, bit_end;

  logic          wr_sel;
  logic [1:0]    reg_sel;
  logic [31:0]   cnt_ext;
  logic [3:0]    cnt_field;
  logic          unused_bits;

  assign reg_sel  = addr_i[3:2];
  assign wr_sel   = ce_i & we_i;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = wr_sel & (reg_sel == 2'd0);
  // Fullness is judged before the edge, so a same-cycle pop never rescues a push into a full FIFO.
  assign push     = push_req & ~full;
  assign busy     = (state != IDLE);
  // A bit period ends when the down-counter has reached 1.
  assign bit_end  = (baud_cnt <= 16'd1);
  assign div_eff  = (bauddiv == 16'd0) ? 16'd1 : bauddiv;
  // Head is taken from IDLE, or straight from the last STOP cycle so back-to-back frames have no gap.
  assign pop      = tx_en & ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign cnt_ext  = 32'(count);
  assign cnt_field = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
  assign tx_o     = tx_q;
  assign int_o    = int_en & empty & ~busy;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  // FIFO pointers, occupancy and storage; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i[7:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Control, divisor and sticky overflow registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      bauddiv  <= DIV_RESET;
      tx_en    <= 1'b0;
      int_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_req && full)
        overflow <= 1'b1;
      else if (wr_sel && reg_sel == 2'd1 && data_i[3])
        overflow <= 1'b0;
      if (wr_sel && reg_sel == 2'd2) bauddiv <= data_i[15:0];
      if (wr_sel && reg_sel == 2'd3) begin
        tx_en  <= data_i[0];
        int_en <= data_i[1];
      end
    end
  end

  // Frame state machine; the divisor is re-read at every bit boundary so updates apply on the next bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= div_eff;
            tx_q     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= div_eff;
            tx_q     <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= div_eff;
            if (bit_cnt == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              tx_q    <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin // STOP
          if (bit_end) begin
            if (pop) begin
              shreg    <= mem[rd_ptr];
              baud_cnt <= div_eff;
              tx_q     <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // Combinational register read-back; zero when not reading
  always_comb begin
    data_o = '0;
    if (ce_i && !we_i) begin
      case (reg_sel)
        2'd1:    data_o = {24'd0, cnt_field, overflow, empty, full, busy};
        2'd2:    data_o = {16'd0, bauddiv};
        2'd3:    data_o = {30'd0, int_en, tx_en};
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: register checks inline, serial frames checked by a scoreboard monitor.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        tx_o;
  logic        int_o;

  uart_tx dut (
    .clk   (clk),
    .rst   (rst),
    .ce_i  (ce_i),
    .we_i  (we_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .data_o(data_o),
    .tx_o  (tx_o),
    .int_o (int_o)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         cur_div = 434;
  logic [7:0] exp_q[$];
  int         start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ce_i = 1'b1; we_i = 1'b1; addr_i = {28'd0, a, 2'b00}; data_i = d;
    @(posedge clk);
    #1;
    ce_i = 1'b0; we_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    ce_i = 1'b1; we_i = 1'b0; addr_i = {28'd0, a, 2'b00};
    #1;
    d = data_o;
    ce_i = 1'b0;
  endtask

  // Poll STATUS each cycle until idle and empty; a timeout counts as a miscompare
  task automatic wait_done(input string name, input int max_cyc);
    logic [31:0] st;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      step(1);
      rd(2'd1, st);
      if (st[0] == 1'b0 && st[2] == 1'b1) done = 1'b1;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  // Monitor: on a start bit, sample every clock of the frame at the falling edge and check shape and byte
  int         m_d, m_k;
  logic [7:0] m_b, m_e;
  logic       m_bad, m_abort;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_o === 1'b0) begin
        m_d = cur_div; m_b = '0; m_bad = 1'b0; m_abort = 1'b0;
        start_q.push_back(cyc);
        for (int s = 0; s < 10 * m_d && !m_abort; s++) begin
          if (s > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            m_abort = 1'b1;
          end else begin
            m_k = s / m_d;
            if (m_k == 0) begin
              if (tx_o !== 1'b0) m_bad = 1'b1;
            end else if (m_k == 9) begin
              if (tx_o !== 1'b1) m_bad = 1'b1;
            end else if (s % m_d == 0) begin
              m_b[m_k-1] = tx_o;
            end else if (tx_o !== m_b[m_k-1]) begin
              m_bad = 1'b1;
            end
          end
        end
        if (!m_abort) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL frame: got unexpected byte 0x%02h, no byte expected", m_b);
          end else begin
            m_e = exp_q.pop_front();
            if (m_bad || m_b !== m_e) begin
              n_err++;
              $display("FAIL frame: got 0x%02h (shape_err=%0b) expected 0x%02h", m_b, m_bad, m_e);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] r;
  logic        bad;
  initial begin : stim
    // Reset and register defaults
    step(3);
    rst = 1'b1;
    chk("idle_data_o", data_o, 32'd0);
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_int", {31'd0, int_o}, 32'd0);
    rd(2'd1, r); chk("rst_status", r, 32'h4);
    rd(2'd2, r); chk("rst_baud", r, 32'd434);
    rd(2'd3, r); chk("rst_ctrl", r, 32'd0);
    rd(2'd0, r); chk("rst_txdata", r, 32'd0);

    // Single 0xA5 frame at 4 clocks per bit, exact timing
    wr(2'd2, 32'd4); cur_div = 4;
    rd(2'd2, r); chk("baud4", r, 32'd4);
    wr(2'd3, 32'd1);
    exp_q.push_back(8'hA5);
    wr(2'd0, 32'hA5);
    chk("a5_pre_tx", {31'd0, tx_o}, 32'd1);
    step(1);
    chk("a5_start_tx", {31'd0, tx_o}, 32'd0);
    rd(2'd1, r); chk("a5_busy_on", {31'd0, r[0]}, 32'd1);
    step(3);
    chk("a5_start_end", {31'd0, tx_o}, 32'd0);
    step(1);
    chk("a5_bit0", {31'd0, tx_o}, 32'd1);
    step(35);
    rd(2'd1, r); chk("a5_busy_39", {31'd0, r[0]}, 32'd1);
    step(1);
    rd(2'd1, r); chk("a5_busy_40", {31'd0, r[0]}, 32'd0);

    // Fill with tx disabled, overflow, clear, then drain at divisor 0 (treated as 1)
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h11);
    rd(2'd1, r); chk("one_push_status", r, 32'h10);
    for (int i = 2; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i * 17));
      wr(2'd0, 32'(i * 17));
    end
    exp_q.push_front(8'h11);
    rd(2'd1, r); chk("full_ovf_status", r, 32'h8A);
    wr(2'd1, 32'h8);
    rd(2'd1, r); chk("ovf_cleared", r, 32'h82);
    cur_div = 1;
    wr(2'd3, 32'd1);
    wait_done("drain8", 200);
    chk("drain8_queue", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with no idle gap
    wr(2'd2, 32'd2); cur_div = 2;
    start_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'hFF);
    wait_done("b2b", 100);
    chk("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) chk("b2b_gap", 32'(start_q[1] - start_q[0]), 32'd20);

    // Drain interrupt
    wr(2'd3, 32'd3);
    chk("int_empty", {31'd0, int_o}, 32'd1);
    exp_q.push_back(8'h3C);
    wr(2'd0, 32'h3C);
    chk("int_after_push", {31'd0, int_o}, 32'd0);
    step(20);
    chk("int_before_stop_end", {31'd0, int_o}, 32'd0);
    step(1);
    chk("int_at_stop_end", {31'd0, int_o}, 32'd1);

    // Reset in the middle of a frame
    wr(2'd3, 32'd1);
    wr(2'd2, 32'd4); cur_div = 4;
    wr(2'd0, 32'h5A);
    step(1);
    step(14);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("mid_rst_tx", {31'd0, tx_o}, 32'd1);
    chk("mid_rst_int", {31'd0, int_o}, 32'd0);
    rd(2'd1, r); chk("mid_rst_status", r, 32'h4);
    rd(2'd2, r); chk("mid_rst_baud", r, 32'd434);
    rd(2'd3, r); chk("mid_rst_ctrl", r, 32'd0);
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx_o !== 1'b1) bad = 1'b1;
    end
    chk("mid_rst_quiet", {31'd0, bad}, 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
